// File: rtl/fpu_uart_pkg.sv
// Shared constants and state encodings for the FPU serial link (transmitter and receiver).
`timescale 1ns/1ps
package fpu_uart_pkg;

    localparam int DEFAULT_CLK_FREQ     = 50_000_000;
    localparam int DEFAULT_BAUD         = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD;
    localparam int DATA_BITS            = 8;
    localparam int WORD_BYTES           = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 byte serializer: start/ready handshake, baud counter, bit counter, flopped tx.
`timescale 1ns/1ps
module uart_tx_byte
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       last,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_byte: STOP_BITS must be 1 or 2");
    end

    tx_state_t        state, state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic             stop_cnt;
    logic [7:0]       shreg;
    logic             tx_q, tx_next;
    logic             bit_end, load, shift;

    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // last is high during the final cycle of the final stop bit; a new start
    // taken on that cycle follows with no idle gap.
    assign last    = (state == ST_STOP) && bit_end && (stop_cnt == 1'(STOP_BITS - 1));
    assign ready   = (state == ST_IDLE) || last;
    assign tx      = tx_q;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        tx_next    = tx_q;
        load       = 1'b0;
        shift      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (start) begin
                    state_next = ST_START;
                    tx_next    = 1'b0;
                    load       = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    tx_next    = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift   = 1'b1;
                        tx_next = shreg[1];
                    end
                end
            end
            ST_STOP: begin
                if (last) begin
                    if (start) begin
                        state_next = ST_START;
                        tx_next    = 1'b0;
                        load       = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state <= state_next;
            tx_q  <= tx_next;
            if (load) begin
                shreg <= data;
            end else if (shift) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            if (state == ST_IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (load) begin
                bit_cnt <= '0;
            end else if (state == ST_DATA && bit_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_STOP && bit_end) begin
                stop_cnt <= last ? 1'b0 : stop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_uart_tx.sv
// FPU result return path: sends a 16-bit word as two back-to-back 8N1 frames, low byte first.
`timescale 1ns/1ps
module fpu_uart_tx
    import fpu_uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] word_data,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    logic       active;
    logic       byte_idx;
    logic       done_q;
    logic [7:0] hi_byte;
    logic       accept;
    logic       byte_start;
    logic [7:0] byte_data;
    logic       ser_ready;
    logic       ser_last;

    assign accept     = !active && word_valid;
    assign word_ready = !active;
    assign busy       = active;
    assign done       = done_q;

    // The low byte goes straight from word_data into the serializer on the accept
    // edge so the start bit appears one cycle later; only the high byte is held here.
    assign byte_data  = active ? hi_byte : word_data[7:0];
    assign byte_start = ser_ready &&
                        (active ? (ser_last && byte_idx != 1'(WORD_BYTES - 1)) : word_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            byte_idx <= 1'b0;
            done_q   <= 1'b0;
            hi_byte  <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                active   <= 1'b1;
                byte_idx <= 1'b0;
                hi_byte  <= word_data[15:8];
            end else if (active && ser_last) begin
                if (byte_idx == 1'(WORD_BYTES - 1)) begin
                    active   <= 1'b0;
                    byte_idx <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .ready (ser_ready),
        .last  (ser_last),
        .tx    (tx)
    );

endmodule

// File: tb/tb_fpu_uart_tx.sv
// Directed bench for fpu_uart_tx: default-rate instance plus a CLKS_PER_BIT=5, STOP_BITS=2 instance.
`timescale 1ns/1ps
module tb_fpu_uart_tx;

    localparam int CPB  = 434;
    localparam int CPB1 = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_data0, word_data1;
    logic        word_valid0, word_valid1;
    logic        word_ready0, word_ready1;
    logic        busy0, busy1;
    logic        done0, done1;
    logic        tx0, tx1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    bit toggle_on;
    logic dn;

    always #10 clk = ~clk;

    fpu_uart_tx dut0 (
        .clk        (clk),
        .rst        (rst),
        .word_data  (word_data0),
        .word_valid (word_valid0),
        .word_ready (word_ready0),
        .busy       (busy0),
        .done       (done0),
        .tx         (tx0)
    );

    fpu_uart_tx #(.CLKS_PER_BIT(CPB1), .STOP_BITS(2)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .word_data  (word_data1),
        .word_valid (word_valid1),
        .word_ready (word_ready1),
        .busy       (busy1),
        .done       (done1),
        .tx         (tx1)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int which);
        return (which != 0) ? tx1 : tx0;
    endfunction

    function automatic logic get_done(input int which);
        return (which != 0) ? done1 : done0;
    endfunction

    // Drives a word for one clock starting at a negedge; returns at the negedge
    // right after the accept edge, i.e. half a cycle into the start bit.
    task automatic send_word(input int which, input logic [15:0] w, input bit release_valid);
        if (which != 0) begin
            word_data1  = w;
            word_valid1 = 1'b1;
        end else begin
            word_data0  = w;
            word_valid0 = 1'b1;
        end
        @(negedge clk);
        acc_cyc = cyc;
        if (release_valid) begin
            if (which != 0) word_valid1 = 1'b0;
            else            word_valid0 = 1'b0;
        end
    endtask

    // Entered half a cycle into a start bit; samples each bit at its centre and
    // returns half a cycle into the first cycle after the frame.
    task automatic rx_byte(input int which, input int cpb, input int nstop, input string tag,
                           input logic [7:0] exp, output logic dn_last);
        logic [7:0] b;
        b = '0;
        repeat (cpb / 2) @(negedge clk);
        check({tag, " start"}, 32'(get_tx(which)), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            b[i] = get_tx(which);
        end
        check({tag, " data"}, 32'(b), 32'(exp));
        for (int j = 0; j < nstop; j++) begin
            repeat (cpb) @(negedge clk);
            check({tag, " stop mid"}, 32'(get_tx(which)), 32'd1);
        end
        repeat (cpb - cpb / 2 - 1) @(negedge clk);
        check({tag, " stop end"}, 32'(get_tx(which)), 32'd1);
        dn_last = get_done(which);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] w;
        rst         = 1'b1;
        word_data0  = '0;
        word_valid0 = 1'b0;
        word_data1  = '0;
        word_valid1 = 1'b0;
        toggle_on   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx0), 32'd1);
        check("rst word_ready", 32'(word_ready0), 32'd1);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        check("rst tx1", 32'(tx1), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle tx", 32'(tx0), 32'd1);

        // 1: single word 0x5780
        send_word(0, 16'h5780, 1'b1);
        check("t1 tx low after accept", 32'(tx0), 32'd0);
        check("t1 busy", 32'(busy0), 32'd1);
        check("t1 word_ready", 32'(word_ready0), 32'd0);
        rx_byte(0, CPB, 1, "t1 b0", 8'h80, dn);
        check("t1 no gap between bytes", 32'(tx0), 32'd0);
        rx_byte(0, CPB, 1, "t1 b1", 8'h57, dn);
        check("t1 done not early", 32'(dn), 32'd0);
        check("t1 done", 32'(done0), 32'd1);
        check("t1 latency", 32'(cyc + 1 - acc_cyc), 32'd8681);
        check("t1 ready at done", 32'(word_ready0), 32'd1);
        check("t1 busy at done", 32'(busy0), 32'd0);
        @(negedge clk);
        check("t1 done one cycle", 32'(done0), 32'd0);
        check("t1 done count", 32'(done_cnt0), 32'd1);

        // 2: back-to-back words with word_valid held high
        send_word(0, 16'h3D05, 1'b0);
        check("t2 w0 start", 32'(tx0), 32'd0);
        word_data0 = 16'h0002;
        rx_byte(0, CPB, 1, "t2 w0 b0", 8'h05, dn);
        rx_byte(0, CPB, 1, "t2 w0 b1", 8'h3D, dn);
        check("t2 w0 done", 32'(done0), 32'd1);
        check("t2 line high in done cycle", 32'(tx0), 32'd1);
        @(negedge clk);
        word_valid0 = 1'b0;
        check("t2 w1 start one cycle after done", 32'(tx0), 32'd0);
        rx_byte(0, CPB, 1, "t2 w1 b0", 8'h02, dn);
        rx_byte(0, CPB, 1, "t2 w1 b1", 8'h00, dn);
        check("t2 w1 done", 32'(done0), 32'd1);
        @(negedge clk);
        check("t2 done count", 32'(done_cnt0), 32'd3);

        // 3: word_valid pulsed while busy is ignored
        send_word(0, 16'h1234, 1'b1);
        fork
            begin
                rx_byte(0, CPB, 1, "t3 b0", 8'h34, dn);
                rx_byte(0, CPB, 1, "t3 b1", 8'h12, dn);
            end
            begin
                repeat (1000) @(negedge clk);
                word_data0  = 16'hFFFF;
                word_valid0 = 1'b1;
                @(negedge clk);
                word_valid0 = 1'b0;
            end
        join
        check("t3 done", 32'(done0), 32'd1);
        repeat (2 * CPB) @(negedge clk);
        check("t3 no extra frame", 32'(tx0), 32'd1);
        check("t3 ready", 32'(word_ready0), 32'd1);
        check("t3 single done", 32'(done_cnt0), 32'd4);

        // 4: reset in byte 1, bit 3 of 0xABCD, then a clean 0x00FF
        send_word(0, 16'hABCD, 1'b1);
        rx_byte(0, CPB, 1, "t4 b0", 8'hCD, dn);
        repeat (CPB / 2 + 4 * CPB) @(negedge clk);
        check("t4 bit3 before reset", 32'(tx0), 32'd1);
        check("t4 busy before reset", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        check("t4 tx async reset", 32'(tx0), 32'd1);
        check("t4 ready async reset", 32'(word_ready0), 32'd1);
        check("t4 busy async reset", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("t4 no done after abort", 32'(done_cnt0), 32'd4);
        check("t4 line idle", 32'(tx0), 32'd1);
        send_word(0, 16'h00FF, 1'b1);
        check("t4 restart start", 32'(tx0), 32'd0);
        rx_byte(0, CPB, 1, "t4 w1 b0", 8'hFF, dn);
        rx_byte(0, CPB, 1, "t4 w1 b1", 8'h00, dn);
        check("t4 w1 done", 32'(done0), 32'd1);
        @(negedge clk);

        // 6: word_data churns every cycle after accept
        send_word(0, 16'hC3C3, 1'b1);
        toggle_on = 1'b1;
        fork
            begin
                rx_byte(0, CPB, 1, "t6 b0", 8'hC3, dn);
                rx_byte(0, CPB, 1, "t6 b1", 8'hC3, dn);
                toggle_on = 1'b0;
            end
            begin
                while (toggle_on) begin
                    word_data0 = 16'($urandom);
                    @(negedge clk);
                end
            end
        join
        check("t6 done", 32'(done0), 32'd1);
        @(negedge clk);
        check("t6 done count", 32'(done_cnt0), 32'd6);

        // 5: CLKS_PER_BIT=5, STOP_BITS=2 instance with random words
        for (int k = 0; k < 24; k++) begin
            w = 16'($urandom);
            send_word(1, w, 1'b1);
            rx_byte(1, CPB1, 2, "t5 b0", w[7:0], dn);
            check("t5 no gap", 32'(tx1), 32'd0);
            rx_byte(1, CPB1, 2, "t5 b1", w[15:8], dn);
            check("t5 done not early", 32'(dn), 32'd0);
            check("t5 done", 32'(done1), 32'd1);
            check("t5 latency", 32'(cyc + 1 - acc_cyc), 32'd111);
            @(negedge clk);
        end
        check("t5 done count", 32'(done_cnt1), 32'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
